// File: rtl/seg_scan_rx.sv
// seg_scan_rx: receives a multiplexed 4-digit 7-segment display scan.
// Samples the anode and cathode pins and decodes stable digit patterns into
// BCD frames. Also tracks link liveness and sticky error flags.
module seg_scan_rx #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  seg_an,
   input  logic [7:0]  seg_cat,
   input  logic        clr_err,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic        changed,
   output logic        link_up,
   output logic        pat_err,
   output logic        an_err
);

   localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0]  STABLE_PRE = 8'(STABLE_CYCLES - 1);
   localparam logic [23:0] TMO_MAX    = 24'(TIMEOUT_CYCLES);
   localparam logic [23:0] TMO_PRE    = 24'(TIMEOUT_CYCLES - 1);

   // Synchronizers, previous-sample register and counters.
   logic [3:0]       an_s1, an_s2, an_q;
   logic [6:0]       cat_s1, cat_s2, cat_q;
   logic [7:0]       stab_cnt;
   logic [23:0]      tmo_cnt;
   logic [3:0][3:0]  digits;
   logic [3:0]       seen;

   // Decode results for the current synchronized sample.
   logic             same;
   logic             capture;
   logic [3:0]       an_low;
   logic             one_low;
   logic             multi_low;
   logic [1:0]       idx;
   logic [3:0]       dec_val;
   logic             dec_ok;
   logic             digit_ok;
   logic [3:0]       seen_set;
   logic [3:0][3:0]  digits_new;
   logic             tmo_hit;

   // Capture detection, anode index and cathode pattern decode.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      idx        = 2'd0;
      dec_val    = 4'd0;
      dec_ok     = 1'b1;
      same       = ({an_s2, cat_s2} == {an_q, cat_q});
      // The capture fires on the edge where the counter steps to STABLE_CYCLES.
      capture    = same && (stab_cnt == STABLE_PRE);
      an_low     = ~an_s2;
      multi_low  = (an_low & (an_low - 4'd1)) != 4'd0;
      one_low    = (an_low != 4'd0) && !multi_low;
      case (an_low)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      case (cat_s2)
         7'h40:   dec_val = 4'd0;
         7'h79:   dec_val = 4'd1;
         7'h24:   dec_val = 4'd2;
         7'h30:   dec_val = 4'd3;
         7'h19:   dec_val = 4'd4;
         7'h12:   dec_val = 4'd5;
         7'h02:   dec_val = 4'd6;
         7'h78:   dec_val = 4'd7;
         7'h00:   dec_val = 4'd8;
         7'h18:   dec_val = 4'd9;
         default: dec_ok  = 1'b0;
      endcase
      digit_ok        = capture && one_low && dec_ok;
      seen_set        = seen | (4'b0001 << idx);
      digits_new      = digits;
      digits_new[idx] = dec_val;
      // A digit accepted on the same edge restarts the timer, so it suppresses the drop.
      tmo_hit         = (tmo_cnt == TMO_PRE) && !digit_ok;
   end

   // Sampling, stability/timeout counting, digit collection and frame output.
   always_ff @(posedge clk) begin
      // NOTE: the reset is synchronous, so it lives inside the clocked branch, not in the sensitivity list.
      if (rst) begin
         an_s1       <= 4'hF;
         an_s2       <= 4'hF;
         an_q        <= 4'hF;
         cat_s1      <= 7'h7F;
         cat_s2      <= 7'h7F;
         cat_q       <= 7'h7F;
         stab_cnt    <= 8'd0;
         tmo_cnt     <= 24'd0;
         digits      <= '0;
         seen        <= 4'h0;
         value       <= 16'h0000;
         frame_valid <= 1'b0;
         changed     <= 1'b0;
         link_up     <= 1'b0;
         pat_err     <= 1'b0;
         an_err      <= 1'b0;
      end else begin
         // NOTE: state updates use non-blocking assignments, so every right-hand side sees pre-edge values.
         an_s1  <= seg_an;
         an_s2  <= an_s1;
         cat_s1 <= seg_cat[6:0];
         cat_s2 <= cat_s1;
         an_q   <= an_s2;
         cat_q  <= cat_s2;

         if (!same)
            stab_cnt <= 8'd0;
         else if (stab_cnt != STABLE_MAX)
            stab_cnt <= stab_cnt + 8'd1;

         if (tmo_cnt != TMO_MAX)
            tmo_cnt <= tmo_cnt + 24'd1;
         if (tmo_hit) begin
            link_up <= 1'b0;
            seen    <= 4'h0;
         end

         frame_valid <= 1'b0;
         changed     <= 1'b0;

         // The clear comes first, so a same-cycle error set below overrides it.
         if (clr_err) begin
            pat_err <= 1'b0;
            an_err  <= 1'b0;
         end

         // A blanking capture (no anode low) matches neither branch and is ignored.
         if (capture) begin
            if (multi_low) begin
               an_err <= 1'b1;
            end else if (one_low) begin
               if (dec_ok) begin
                  digits[idx] <= dec_val;
                  tmo_cnt     <= 24'd0;
                  if (seen_set == 4'hF) begin
                     value       <= digits_new;
                     frame_valid <= 1'b1;
                     changed     <= (digits_new != value);
                     link_up     <= 1'b1;
                     seen        <= 4'h0;
                  end else begin
                     seen <= seen_set;
                  end
               end else begin
                  pat_err   <= 1'b1;
                  seen[idx] <= 1'b0;
               end
            end
         end
      end
   end

endmodule
